mul_add: RTL

Sequential unsigned multiply-add computing x = q * y + r, one multiplier bit per clock. It is the inverse of the `divider` block. Given a quotient, divisor and remainder, it reconstructs the dividend and flags results that do not fit in WIDTH bits. Its start/busy/val handshake matches `divider`, so a bench or datapath can chain the two back-to-back for round-trip checks.

---
 rtl/mul_add.sv | 92 +++++++++
 1 files changed

// File: rtl/mul_add.sv
// Sequential unsigned multiply-add x = q*y + r, one multiplier bit per clock.
// Companion to the divider block: same start/busy/val handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result (if any) held on x/ovf/val
// RUN   | shift-and-add iteration, cnt counts 0..WIDTH-1
module mul_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             val,
  output logic             ovf,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] x
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic               accept;
  logic               zero_op;
  logic               last;

  assign accept  = (state == IDLE) && start;
  assign zero_op = (q == '0) || (y == '0);
  assign last    = (cnt == CNT_LAST);
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !zero_op) state_nxt = RUN;
      RUN:  if (last)              state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      x      <= '0;
      ovf    <= 1'b0;
      val    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      mplier <= q;
      mcand  <= {{WIDTH{1'b0}}, y};
      acc    <= {{WIDTH{1'b0}}, r};
      // A zero factor means the result is just r; finish on the accept edge.
      x      <= zero_op ? r : '0;
      ovf    <= 1'b0;
      val    <= zero_op;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        x   <= acc_sum[WIDTH-1:0];
        ovf <= |acc_sum[2*WIDTH-1:WIDTH];
        val <= 1'b1;
      end
    end
  end

endmodule
